// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use stalls, taken-branch
// squash, data-memory freeze, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memrd,
  input  logic             ex_regwrt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    SQUASH  = 2'b10,
    MEMWAIT = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   lu;
  logic   br_accept;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign lu = ex_memrd && ex_regwrt && (ex_rd != '0) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = RUN;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    br_accept    = 1'b0;
    case (state_q)
      RUN, LDSTALL: begin
        if (mem_busy) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          state_d  = MEMWAIT;
        end else if (br_taken) begin
          ifid_flush   = 1'b1;
          idex_bubble  = 1'b1;
          exmem_bubble = 1'b1;
          br_accept    = 1'b1;
          state_d      = SQUASH;
        end else if (lu && (state_q == RUN)) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = LDSTALL;
        end
      end
      SQUASH, MEMWAIT: begin
        // ID holds a NOP / buffers are frozen: only the memory freeze matters here.
        if (mem_busy) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          state_d  = MEMWAIT;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset forces every buffer to hold a bubble regardless of state.
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      br_accept    = 1'b0;
    end
  end

  assign state = 2'(state_q);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_accept && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 6;

  logic clk, rst_n;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_memrd, ex_regwrt, br_taken, mem_busy;

  logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_ifid_flush, s_idex_bubble, s_exmem_bubble;
  logic [1:0] s_state;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_memrd(ex_memrd), .ex_regwrt(ex_regwrt), .ex_rd(ex_rd),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_memrd(ex_memrd), .ex_regwrt(ex_regwrt), .ex_rd(ex_rd),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .idex_en(s_idex_en), .exmem_en(s_exmem_en), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pipeline mode plus unbounded event tallies.
  int m_mode  = 0;   // 0 run, 1 load stall, 2 squash, 3 memory wait
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic set_in(input bit mb, input bit br, input bit memrd, input bit regwrt,
                        input int rd, input int rs, input int rt, input bit urs, input bit urt);
    mem_busy = mb; br_taken = br; ex_memrd = memrd; ex_regwrt = regwrt;
    ex_rd = REG_W'(rd); id_rs = REG_W'(rs); id_rt = REG_W'(rt);
    id_use_rs = urs; id_use_rt = urt;
  endtask

  // Check one cycle at the falling edge, then advance the model on the rising edge.
  task automatic step(input string tag);
    bit hazard, freeze, take_br, take_lu;
    logic [6:0] exp_ctrl;
    int nxt;
    @(negedge clk);
    if (!rst_n) begin
      m_mode = 0; m_stall = 0; m_flush = 0;
    end
    hazard = ex_memrd && ex_regwrt && (ex_rd != 0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    freeze  = mem_busy;
    take_br = !freeze && br_taken && (m_mode == 0 || m_mode == 1);
    take_lu = !freeze && !take_br && hazard && (m_mode == 0);
    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble}
    if (!rst_n)       begin exp_ctrl = 7'b0000_111; nxt = 0; end
    else if (freeze)  begin exp_ctrl = 7'b0000_000; nxt = 3; end
    else if (take_br) begin exp_ctrl = 7'b1111_111; nxt = 2; end
    else if (take_lu) begin exp_ctrl = 7'b0011_010; nxt = 1; end
    else              begin exp_ctrl = 7'b1111_000; nxt = 0; end
    chk({tag, ".ctrl"}, 32'({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble}),
        32'(exp_ctrl));
    chk({tag, ".ctrl4"}, 32'({s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_ifid_flush, s_idex_bubble,
        s_exmem_bubble}), 32'(exp_ctrl));
    chk({tag, ".state"}, 32'(state), 32'(m_mode));
    chk({tag, ".state4"}, 32'(s_state), 32'(m_mode));
    chk({tag, ".stall"}, 32'(stall_cnt), 32'(sat(m_stall, 16)));
    chk({tag, ".flush"}, 32'(flush_cnt), 32'(sat(m_flush, 16)));
    chk({tag, ".stall4"}, 32'(s_stall_cnt), 32'(sat(m_stall, 4)));
    chk({tag, ".flush4"}, 32'(s_flush_cnt), 32'(sat(m_flush, 4)));
    @(posedge clk);
    if (rst_n) begin
      if (exp_ctrl[6] == 1'b0) m_stall++;
      if (take_br) m_flush++;
      m_mode = nxt;
    end
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_in();
    set_in($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step("reset");
    end
    rst_n = 1'b1;
    idle();
    step("release");

    // Load-use on rs, then the stall cycle, then back to run.
    set_in(0, 0, 1, 1, 5, 5, 0, 1, 0);
    step("lu");
    step("lu_hold");
    idle();
    step("lu_after");
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    set_in(0, 0, 1, 1, 0, 0, 0, 1, 0);
    step("lu_r0");
    set_in(0, 0, 1, 1, 5, 5, 0, 0, 0);
    step("lu_nouse");
    set_in(0, 0, 1, 1, 7, 1, 7, 0, 1);
    step("lu_rt");
    idle();
    step("lu_rt_after");

    // Taken branch, then a hazard and a second branch presented during squash.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("br");
    set_in(0, 1, 1, 1, 5, 5, 0, 1, 0);
    step("squash");
    idle();
    step("br_after");
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Four-cycle memory wait with a branch held across it.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
      step("memwait");
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("mem_exit");
    step("mem_br");
    idle();
    step("mem_after");

    // Priority combinations.
    set_in(0, 1, 1, 1, 5, 5, 0, 1, 0);
    step("pri_br_lu");
    idle();
    step("pri_idle");
    set_in(1, 1, 1, 1, 5, 5, 0, 1, 0);
    step("pri_all");
    idle();
    step("pri_exit");
    step("pri_idle2");

    // Long freeze saturates the narrow counter; then reset in the middle of it.
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("sat");
    end
    chk("sat_stall4", 32'(s_stall_cnt), 32'd15);
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_stall", 32'(stall_cnt), 32'd0);
    chk("async_pc_en", 32'(pc_en), 32'd0);
    step("mid_reset");
    rst_n = 1'b1;
    idle();
    step("post_reset");

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      rand_in();
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
